data_memory_master: RTL

- Initiator for the 256x32 data memory unit. It accepts load/store requests from the processor datapath over a valid/ready handshake.
- It drives the memory's en/wen/addr/data_in and captures the memory's registered data_out.
- It supports single-word stores and burst loads of 1..16 consecutive words, with a backpressured response stream.
- It sits between the execute/memory pipeline stage and data_memory_unit.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/data_memory_master.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data memory master.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [LEN_W-1:0]  len;
    } dmem_req_t;

endpackage

// File: rtl/data_memory_master.sv
// Initiator for the 256x32 data memory: single-word stores, 1..16 word burst loads.
// Latency: store occupies 2 cycles; each load word appears 3 cycles after its issue point.
// Backpressure: req_ready only in IDLE; while rsp_ready=0 the response holds and no read is issued.
module data_memory_master
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_state_t       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_count;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_last;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_mem_en;
    logic              r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    dmem_req_t         w_req;
    logic [ADDR_W-1:0] w_addr_nxt;

    assign w_req      = '{we: req_we, addr: req_addr, wdata: req_wdata, len: req_len};
    // Burst address wraps naturally at the top of the word space.
    assign w_addr_nxt = r_addr + ADDR_W'(1);

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_last   = r_rsp_last;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != IDLE);
    assign mem_en     = r_mem_en;
    assign mem_wen    = r_mem_wen;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

    // Control FSM; every output is registered as the value for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Handshake uses the registered ready, so the first cycle out of reset accepts nothing.
                    if (req_valid && r_req_ready) begin
                        r_addr      <= w_req.addr;
                        r_count     <= w_req.len;
                        r_req_ready <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= w_req.addr;
                        if (w_req.we) begin
                            r_mem_wen   <= 1'b1;
                            r_mem_wdata <= w_req.wdata;
                            r_state     <= WRITE;
                        end else begin
                            r_state     <= RD_ISSUE;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    r_mem_en    <= 1'b0;
                    r_mem_wen   <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                RD_ISSUE: begin
                    r_mem_en   <= 1'b0;
                    r_mem_addr <= '0;
                    r_state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    // mem_rdata is sampled before the memory clears it on this same edge.
                    r_rsp_data  <= mem_rdata;
                    r_rsp_last  <= (r_count == '0);
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                        if (r_count == '0) begin
                            r_req_ready <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_addr     <= w_addr_nxt;
                            r_count    <= r_count - LEN_W'(1);
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= w_addr_nxt;
                            r_state    <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_mem_en    <= 1'b0;
                    r_mem_wen   <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
